intr_ctrl: RTL and testbench
============================

# intr_ctrl

Interrupt sequencer that owns the write side of the CP0 exception path. Latches four external interrupt lines as pending bits and filters them through the CP0 status enable and mask. Picks one winner by fixed priority and drains the pipeline to an instruction boundary. It then issues the single-cycle EPC write and vector jump, and holds the in-service state until `eret`. Sits between the interrupt pins, the pipeline control unit and CP0.

## Interface
- `ADDR_W`, default `IM_ADDR_BIT`, width of word-addressed instruction memory PC
- `VEC_BASE`, default 'h200 (word address), handler vector for source 0
- `VEC_STRIDE`, default 'h20 (words), vector spacing between sources
- `clk  in  1  system clock; all state changes on posedge`
- `rst  in  1  synchronous, active-high reset`
- `intr_req  in  4  raw interrupt lines, rising-edge sensitive, already synchronous to clk`
- `intr_en  in  1  CP0 status[0]`
- `intr_mask  in  4  CP0 status[11:8]; bit i enables source i`
- `is_eret  in  1  eret committing this cycle`
- `safe  in  1  pipeline at instruction boundary: no stall, no branch/jump in flight, resume_pc valid`
- `resume_pc  in  ADDR_W  word address of the next instruction to execute`
- `drain_req  out  1  asks pipeline to stop fetching new instructions and drain`
- `epc_w_en  out  1  to CP0 epc_w_en`
- `epc_w_data  out  ADDR_W  to CP0 epc_w_data`
- `jump_en  out  1  forces PC redirect this cycle`
- `jump_addr  out  ADDR_W  handler vector`
- `pending  out  4  latched, not yet serviced requests`
- `in_service  out  1  handler running`
- `cur_id  out  2  source being entered/serviced`

## Operation
- Edge latch: `prev_req` registered each cycle; `pending[i]` is set on `intr_req[i] & ~prev_req[i]`. It is cleared only in ENTER for `i == cur_id`. Set and clear of the same bit in the same cycle: set wins.
- `eligible = pending & intr_mask & {4{intr_en}}`. Priority: lowest index wins.
- States: IDLE, WAIT_SAFE, ENTER, SERVICE.
- IDLE: if `eligible != 0` and `!is_eret`, latch the winner into `cur_id` and go to WAIT_SAFE.
- WAIT_SAFE: `drain_req = 1`.
  - If `eligible[cur_id] == 0` (enable or mask dropped by mtc0): go to IDLE. The pending bit is kept.
  - Else if `safe`: go to ENTER.
  - The abort check has priority over `safe`.
- ENTER, exactly one cycle:
  - `epc_w_en = 1`, `epc_w_data = resume_pc` (the value sampled in this cycle).
  - `jump_en = 1`, `jump_addr = VEC_BASE + cur_id * VEC_STRIDE`, truncated to ADDR_W.
  - Clear `pending[cur_id]`; go to SERVICE.
  - `drain_req` stays 1.
- SERVICE: `in_service = 1`. New edges still set pending. Nesting is not supported. On `is_eret` go to IDLE.
- `is_eret` outside SERVICE is ignored by the FSM; CP0 still sets `intr_en`.
- Invariant: `epc_w_en` is never asserted in the same cycle as `is_eret`, since CP0 gives the EPC write priority and would drop the eret.

## Timing
- Reset: state IDLE.
  - `pending`, `prev_req`, `cur_id` = 0.
  - All outputs 0.
  - A line held high through reset registers an edge in the first cycle after `rst` deasserts.
- Edge at cycle N: `pending` visible at N+1; WAIT_SAFE at N+2 if eligible. With `safe` already high, ENTER at N+3 and SERVICE at N+4.
- `epc_w_en` and `jump_en` are registered-state decodes, high in exactly one cycle per entry.
- `in_service` rises the cycle after ENTER and falls the cycle after `is_eret`.
- An `rst` pulse in any state returns to IDLE next edge and drops all pending requests. No partial EPC write occurs: ENTER outputs are combinational from state, and state is reset.

## Structure
- Shared in `Core.vh`:
  - `INTR_NUM` = 4
  - state encodings `INTR_S_IDLE`/`_WAIT`/`_ENTER`/`_SVC` (2 bits)
  - `INTR_VEC_BASE`, `INTR_VEC_STRIDE` defaults
- One sub-module, `intr_pending`: edge detect, pending register, set/clear arbitration, priority encoder. It outputs `pending`, `any_eligible` and `winner_id`. The FSM and the vector adder live in `intr_ctrl`.

## Test plan
- Mask 'hF, `intr_en=1`, `safe=1`, pulse `intr_req[2]` at cycle 10 -> `epc_w_en`/`jump_en` at cycle 13, `jump_addr = 'h240`, `epc_w_data = resume_pc`, `pending = 0` at 14.
- Edges on sources 3 and 1 in the same cycle -> source 1 entered first (`jump_addr 'h220`). After `is_eret`, source 3 entered (`'h260`).
- Hold `safe = 0` for 20 cycles in WAIT_SAFE -> `drain_req = 1` throughout and no `epc_w_en`. Raise `safe` -> ENTER next cycle.
- In WAIT_SAFE, drop `intr_mask[cur_id]` -> return to IDLE, pending bit still set. Restore mask -> entry resumes.
- During SERVICE, pulse `intr_req[0]` -> `pending[0] = 1`, no entry until `is_eret`. Then entry with `is_eret` never coinciding with `epc_w_en`.
- Assert `rst` in ENTER and in SERVICE -> next cycle all outputs 0 and state IDLE. Line held high across reset -> `pending` set one cycle after release.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared constants, state encoding and priority helper for the interrupt sequencer.
package intr_ctrl_pkg;

    localparam int unsigned IM_ADDR_BIT     = 12;
    localparam int unsigned INTR_NUM        = 4;
    localparam logic [31:0] INTR_VEC_BASE   = 32'h200;
    localparam logic [31:0] INTR_VEC_STRIDE = 32'h20;

    typedef enum logic [1:0] {
        INTR_S_IDLE  = 2'd0,
        INTR_S_WAIT  = 2'd1,
        INTR_S_ENTER = 2'd2,
        INTR_S_SVC   = 2'd3
    } intr_state_t;

    // Fixed priority: lowest index wins; result is don't-care when v == 0.
    function automatic logic [1:0] lowest_set(input logic [INTR_NUM-1:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/intr_ctrl_pending.sv
// Edge-detected pending register with set-over-clear arbitration and priority pick.
module intr_pending
    import intr_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INTR_NUM-1:0] intr_req,
    input  logic                intr_en,
    input  logic [INTR_NUM-1:0] intr_mask,
    input  logic                clr,
    input  logic [1:0]          clr_id,
    output logic [INTR_NUM-1:0] pending,
    output logic                any_eligible,
    output logic [1:0]          winner_id
);

    logic [INTR_NUM-1:0] prev_req;
    logic [INTR_NUM-1:0] rise;
    logic [INTR_NUM-1:0] clr_vec;
    logic [INTR_NUM-1:0] eligible;

    always_comb begin
        rise    = intr_req & ~prev_req;
        clr_vec = '0;
        if (clr) clr_vec[clr_id] = 1'b1;
        eligible = pending & intr_mask & {INTR_NUM{intr_en}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_req <= '0;
            pending  <= '0;
        end else begin
            prev_req <= intr_req;
            // OR-ing rise after the clear lets a fresh edge win over the clear.
            pending  <= (pending & ~clr_vec) | rise;
        end
    end

    assign any_eligible = |eligible;
    assign winner_id    = lowest_set(eligible);

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt entry sequencer: waits for an instruction boundary, writes EPC and jumps to the vector.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = IM_ADDR_BIT,
    parameter logic [31:0] VEC_BASE   = INTR_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = INTR_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INTR_NUM-1:0] intr_req,
    input  logic                intr_en,
    input  logic [INTR_NUM-1:0] intr_mask,
    input  logic                is_eret,
    input  logic                safe,
    input  logic [ADDR_W-1:0]   resume_pc,
    output logic                drain_req,
    output logic                epc_w_en,
    output logic [ADDR_W-1:0]   epc_w_data,
    output logic                jump_en,
    output logic [ADDR_W-1:0]   jump_addr,
    output logic [INTR_NUM-1:0] pending,
    output logic                in_service,
    output logic [1:0]          cur_id
);

    intr_state_t state;
    logic        any_eligible;
    logic [1:0]  winner_id;
    logic        cur_eligible;
    logic        entering;

    assign entering = (state == INTR_S_ENTER);

    intr_pending u_pending (
        .clk          (clk),
        .rst          (rst),
        .intr_req     (intr_req),
        .intr_en      (intr_en),
        .intr_mask    (intr_mask),
        .clr          (entering),
        .clr_id       (cur_id),
        .pending      (pending),
        .any_eligible (any_eligible),
        .winner_id    (winner_id)
    );

    assign cur_eligible = pending[cur_id] & intr_mask[cur_id] & intr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INTR_S_IDLE;
            cur_id <= '0;
        end else begin
            case (state)
                INTR_S_IDLE: begin
                    if (any_eligible && !is_eret) begin
                        cur_id <= winner_id;
                        state  <= INTR_S_WAIT;
                    end
                end
                INTR_S_WAIT: begin
                    // Losing eligibility aborts the entry even if safe is high.
                    if (!cur_eligible)  state <= INTR_S_IDLE;
                    else if (safe)      state <= INTR_S_ENTER;
                end
                INTR_S_ENTER: state <= INTR_S_SVC;
                INTR_S_SVC:   if (is_eret) state <= INTR_S_IDLE;
                default:      state <= INTR_S_IDLE;
            endcase
        end
    end

    always_comb begin
        drain_req  = (state == INTR_S_WAIT) || entering;
        in_service = (state == INTR_S_SVC);
        epc_w_en   = entering;
        jump_en    = entering;
        epc_w_data = entering ? resume_pc : '0;
        jump_addr  = entering ? ADDR_W'(VEC_BASE + VEC_STRIDE * 32'(cur_id)) : '0;
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized and directed bench for intr_ctrl against a behavioural sequencer model.
module tb_intr_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    intr_req;
    logic          intr_en;
    logic [3:0]    intr_mask;
    logic          is_eret;
    logic          safe;
    logic [AW-1:0] resume_pc;
    logic          drain_req, epc_w_en, jump_en, in_service;
    logic [AW-1:0] epc_w_data, jump_addr;
    logic [3:0]    pending;
    logic [1:0]    cur_id;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.ADDR_W(AW), .VEC_BASE(32'h200), .VEC_STRIDE(32'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .intr_req   (intr_req),
        .intr_en    (intr_en),
        .intr_mask  (intr_mask),
        .is_eret    (is_eret),
        .safe       (safe),
        .resume_pc  (resume_pc),
        .drain_req  (drain_req),
        .epc_w_en   (epc_w_en),
        .epc_w_data (epc_w_data),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pending    (pending),
        .in_service (in_service),
        .cur_id     (cur_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for boundary, 2 entering, 3 handler running.
    bit [3:0] m_pend, m_prev, m_elig, m_next;
    int       m_ph = 0;
    int       m_id = 0;
    bit       m_valid = 0;

    function automatic int first_one(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = '0; m_prev = '0; m_ph = 0; m_id = 0; m_valid = 1;
        end else if (m_valid) begin
            m_elig = m_pend & intr_mask & {4{intr_en}};
            m_next = m_pend;
            case (m_ph)
                0: if (m_elig != 0 && !is_eret) begin m_id = first_one(m_elig); m_ph = 1; end
                1: if (!m_elig[m_id]) m_ph = 0; else if (safe) m_ph = 2;
                2: begin m_next[m_id] = 1'b0; m_ph = 3; end
                default: if (is_eret) m_ph = 0;
            endcase
            m_pend = m_next | (intr_req & ~m_prev);
            m_prev = intr_req;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("drain_req",  32'(drain_req),  32'(m_ph == 1 || m_ph == 2));
            chk("epc_w_en",   32'(epc_w_en),   32'(m_ph == 2));
            chk("jump_en",    32'(jump_en),    32'(m_ph == 2));
            chk("epc_w_data", 32'(epc_w_data), (m_ph == 2) ? 32'(resume_pc) : 32'h0);
            chk("jump_addr",  32'(jump_addr),  (m_ph == 2) ? 32'h200 + 32'(m_id) * 32'h20 : 32'h0);
            chk("pending",    32'(pending),    32'(m_pend));
            chk("in_service", 32'(in_service), 32'(m_ph == 3));
            chk("cur_id",     32'(cur_id),     32'(m_id));
            chk("epc_vs_eret", 32'(epc_w_en & is_eret), 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic eret_out();
        is_eret = 1'b1; step(1); is_eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; intr_req = '0; intr_en = 1'b1; intr_mask = 4'hF;
        is_eret = 1'b0; safe = 1'b1; resume_pc = 12'h123;
        step(3);
        at_neg();
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_outputs", 32'({drain_req, epc_w_en, jump_en, in_service, cur_id}), 32'h0);
        rst = 1'b0;
        step(2);

        // Single source 2 with safe high: entry three cycles after the edge cycle.
        intr_req = 4'b0100; step(1); intr_req = '0;
        at_neg(); chk("s1_pending", 32'(pending), 32'h4);
        step(1); at_neg(); chk("s1_drain", 32'(drain_req), 32'h1);
        step(1); at_neg();
        chk("s1_epc_en",  32'(epc_w_en),   32'h1);
        chk("s1_jump",    32'(jump_addr),  32'h240);
        chk("s1_epc",     32'(epc_w_data), 32'h123);
        step(1); at_neg();
        chk("s1_pend_clr", 32'(pending),   32'h0);
        chk("s1_in_svc",   32'(in_service), 32'h1);
        eret_out(); at_neg(); chk("s1_svc_off", 32'(in_service), 32'h0);
        step(2);

        // Sources 3 and 1 together: 1 first, 3 after eret.
        intr_req = 4'b1010; step(1); intr_req = '0;
        at_neg(); chk("s2_pending", 32'(pending), 32'hA);
        step(2); at_neg(); chk("s2_first", 32'(jump_addr), 32'h220);
        step(3); eret_out();
        step(2); at_neg(); chk("s2_second", 32'(jump_addr), 32'h260);
        step(2); eret_out(); step(2);

        // Held off by safe low for 20 cycles.
        safe = 1'b0;
        intr_req = 4'b0001; step(1); intr_req = '0;
        step(1);
        for (int i = 0; i < 20; i++) begin
            at_neg();
            chk("s3_drain_hold", 32'({drain_req, epc_w_en}), 32'h2);
            step(1);
        end
        safe = 1'b1;
        step(1); at_neg(); chk("s3_enter", 32'(epc_w_en), 32'h1);
        step(1); eret_out(); step(2);

        // Mask dropped in WAIT_SAFE aborts, entry resumes when restored.
        safe = 1'b0;
        intr_req = 4'b0010; step(1); intr_req = '0;
        step(1); intr_mask = 4'b1101;
        step(1); at_neg();
        chk("s4_abort_drain", 32'(drain_req), 32'h0);
        chk("s4_kept",        32'(pending),   32'h2);
        intr_mask = 4'hF; safe = 1'b1;
        step(2); at_neg(); chk("s4_resume", 32'(jump_addr), 32'h220);
        step(1); eret_out(); step(2);

        // New edge during service waits for eret.
        intr_req = 4'b0100; step(1); intr_req = '0;
        step(3); intr_req = 4'b0001; step(1); intr_req = '0;
        at_neg(); chk("s5_pend0", 32'(pending), 32'h1);
        step(4); at_neg(); chk("s5_no_nest", 32'({in_service, epc_w_en}), 32'h2);
        eret_out();
        step(2); at_neg(); chk("s5_entry0", 32'(jump_addr), 32'h200);
        step(1); eret_out(); step(2);

        // Reset during ENTER, during SERVICE, and with a line held high across it.
        intr_req = 4'b1000; step(1); intr_req = '0;
        step(2); rst = 1'b1; step(1); rst = 1'b0;
        at_neg(); chk("s6_rst_enter", 32'({pending, drain_req, epc_w_en, jump_en, in_service, cur_id}), 32'h0);
        step(2);
        intr_req = 4'b0010; step(1); intr_req = '0;
        step(3); rst = 1'b1; step(1); rst = 1'b0;
        at_neg(); chk("s6_rst_svc", 32'({pending, in_service, cur_id}), 32'h0);
        intr_req = 4'b0010; rst = 1'b1; step(2); rst = 1'b0;
        at_neg(); chk("s6_held_r0", 32'(pending), 32'h0);
        step(1); at_neg(); chk("s6_held_r1", 32'(pending), 32'h2);
        intr_req = '0;
        step(3); eret_out(); step(2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1);
            intr_req = intr_req ^ (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
            if ($urandom_range(0, 15) == 0)      intr_mask = 4'($urandom);
            else if ($urandom_range(0, 7) == 0)  intr_mask = 4'hF;
            intr_en   = ($urandom_range(0, 19) != 0);
            safe      = ($urandom_range(0, 2) != 0);
            resume_pc = AW'($urandom);
            is_eret   = (m_ph == 3 && $urandom_range(0, 5) == 0) ||
                        (m_ph == 0 && $urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        step(1);
        at_neg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
